// File: rtl/foobar_evt_fifo.sv
// foobar_evt_fifo
//   Captures foo/bar strobe events from the foobar counter stage.
//   Each event is stamped with a free-running timestamp and queued
//   in a small circular FIFO. The queue drains over valid/ready.
//
// Parameters
//   DEPTH : FIFO entries, power of two, 2..64
//   TS_W  : timestamp width
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   en                    : capture / timestamp enable
//   foo, bar              : event strobes
//   count_foo, count_bar  : counts sampled into each record
//   evt_valid, evt_ready  : drain handshake
//   evt_data              : head record {kind, count_foo, count_bar, ts}
//   level                 : occupied entries
//   drop_cnt              : records lost on a full FIFO
//
// Optional feature
//   FOOBAR_EVT_DROP_CNT_EN : build the saturating drop counter.
//                            Without it, drop_cnt is tied to 0.
module foobar_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      foo,
    input  logic                      bar,
    input  logic [7:0]                count_foo,
    input  logic [7:0]                count_bar,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [18+TS_W-1:0]        evt_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic [7:0]                drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]      kind;
        logic [7:0]      cnt_foo;
        logic [7:0]      cnt_bar;
        logic [TS_W-1:0] ts;
    } evt_t;

    logic [TS_W-1:0] ts;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    evt_t            mem [DEPTH];
    evt_t            rec;

    logic push_req;
    logic full;
    logic pop;
    logic push;

    assign push_req = en & (foo | bar);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign pop      = evt_valid & evt_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push     = push_req & (~full | pop);

    // kind is {bar, foo}, so 01/10/11 fall out directly; 00 cannot push.
    assign rec = '{kind: {bar, foo}, cnt_foo: count_foo, cnt_bar: count_bar, ts: ts};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= '0;
        end else if (en) begin
            ts <= ts + 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; stale entries are masked by evt_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rec;
    end

    assign level     = cnt;
    assign evt_valid = (cnt != '0);
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

`ifdef FOOBAR_EVT_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_q;

    assign drop = push_req & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && drop_q != 8'hFF) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_foobar_evt_fifo.sv
module tb_foobar_evt_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        foo;
    logic        bar;
    logic [7:0]  count_foo;
    logic [7:0]  count_bar;
    logic        evt_ready;

    logic        evt_valid;
    logic [25:0] evt_data;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;

    logic        evt_valid4;
    logic [21:0] evt_data4;
    logic [3:0]  level4;
    logic [7:0]  drop_cnt4;

    int ncmp  = 0;
    int nfail = 0;
    logic [7:0] exp_drop;

    always #5 clk = ~clk;

    foobar_evt_fifo #(.DEPTH(8), .TS_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .foo(foo), .bar(bar),
        .count_foo(count_foo), .count_bar(count_bar),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .level(level), .drop_cnt(drop_cnt)
    );

    foobar_evt_fifo #(.DEPTH(8), .TS_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .foo(foo), .bar(bar),
        .count_foo(count_foo), .count_bar(count_bar),
        .evt_valid(evt_valid4), .evt_ready(evt_ready), .evt_data(evt_data4),
        .level(level4), .drop_cnt(drop_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef FOOBAR_EVT_DROP_CNT_EN
        exp_drop = 8'd2;
`else
        exp_drop = 8'd0;
`endif
        rst = 1'b1; en = 1'b0; foo = 1'b0; bar = 1'b0;
        count_foo = '0; count_bar = '0; evt_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_data", 64'(evt_data), 64'd0);
        #11;
        rst = 1'b0;

        // Idle with no strobes; ts also held (en=0)
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_valid", 64'(evt_valid), 64'd0);
            chk("idle_level", 64'(level), 64'd0);
            chk("idle_drop", 64'(drop_cnt), 64'd0);
        end

        // Advance ts to 5
        en = 1'b1;
        repeat (5) tick();

        // Single event at ts=5, ready held high: no fall-through
        foo = 1'b1; count_foo = 8'd3; count_bar = 8'd0; evt_ready = 1'b1;
        tick();
        foo = 1'b0;
        chk("single_valid", 64'(evt_valid), 64'd1);
        chk("single_level", 64'(level), 64'd1);
        chk("single_data", 64'(evt_data), 64'({2'b01, 8'd3, 8'd0, 8'd5}));
        tick();
        chk("single_drain_level", 64'(level), 64'd0);
        chk("single_drain_valid", 64'(evt_valid), 64'd0);

        // Both strobes at ts=7
        evt_ready = 1'b0;
        foo = 1'b1; bar = 1'b1; count_foo = 8'd5; count_bar = 8'd3;
        tick();
        foo = 1'b0; bar = 1'b0;
        chk("both_data", 64'(evt_data), 64'({2'b11, 8'd5, 8'd3, 8'd7}));
        evt_ready = 1'b1;
        tick();
        chk("both_drain_level", 64'(level), 64'd0);

        // Fill: 10 pushes at ts=9..18, last two dropped
        evt_ready = 1'b0;
        count_bar = 8'd0;
        for (int i = 0; i < 10; i++) begin
            foo = 1'b1; count_foo = 8'(i);
            tick();
        end
        chk("fill_level", 64'(level), 64'd8);
        chk("fill_drop", 64'(drop_cnt), 64'(exp_drop));
        chk("fill_head", 64'(evt_data), 64'({2'b01, 8'd0, 8'd0, 8'd9}));

        // Full, push and pop together at ts=19
        count_foo = 8'd100; evt_ready = 1'b1;
        tick();
        foo = 1'b0; en = 1'b0;
        chk("fullpp_level", 64'(level), 64'd8);
        chk("fullpp_drop", 64'(drop_cnt), 64'(exp_drop));

        // Drain: records 1..7 then the concurrent one
        for (int k = 1; k < 8; k++) begin
            chk("drain_data", 64'(evt_data), 64'({2'b01, 8'(k), 8'd0, 8'(9 + k)}));
            tick();
        end
        chk("drain_last", 64'(evt_data), 64'({2'b01, 8'd100, 8'd0, 8'd19}));
        tick();
        chk("drain_empty_level", 64'(level), 64'd0);
        chk("drain_empty_valid", 64'(evt_valid), 64'd0);
        chk("drain_drop_hold", 64'(drop_cnt), 64'(exp_drop));

        // Clear both instances, then check 4-bit ts wrap on dut4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b1; evt_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            foo = 1'b1; count_foo = 8'(k);
            tick();
            chk("wrap_data", 64'(evt_data4), 64'({2'b01, 8'(k), 8'd0, 4'(k)}));
            chk("wrap_level", 64'(level4), 64'd1);
        end

        // Build level=3, then reset between edges
        evt_ready = 1'b0;
        repeat (2) tick();
        foo = 1'b0;
        chk("pre_rst_level", 64'(level4), 64'd3);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(evt_valid4), 64'd0);
        chk("async_rst_level", 64'(level4), 64'd0);
        chk("async_rst_level8", 64'(level), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_level", 64'(level4), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/foobar_evt_fifo.md
# foobar_evt_fifo

Downstream consumer of the `foobar` counter stage. It watches the `foo`/`bar` strobes and samples `count_foo`/`count_bar` with a free-running timestamp on every cycle in which either strobe is high. Each sample is queued as one event record in a small FIFO and drained over a valid/ready interface to a logger or bus bridge. It decouples the bursty `foobar` event stream from a consumer that can stall.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `TS_W`, 8: timestamp width in bits.

Ports:
- `clk`  in  1  single clock; all state is clocked on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  capture and timestamp enable; same signal that drives `foobar`.
- `foo`  in  1  foo strobe from `foobar`.
- `bar`  in  1  bar strobe from `foobar`.
- `count_foo`  in  8  foo count from `foobar`.
- `count_bar`  in  8  bar count from `foobar`.
- `evt_valid`  out  1  head record is present on `evt_data`.
- `evt_ready`  in  1  consumer accepts the head record.
- `evt_data`  out  18+TS_W  event record, packed as {kind[1:0], count_foo[7:0], count_bar[7:0], ts[TS_W-1:0]}.
- `level`  out  $clog2(DEPTH)+1  number of occupied entries.
- `drop_cnt`  out  8  records lost because the FIFO was full.

## Operation
- Timestamp `ts`:
  - Increments by 1 every cycle while `en`=1 and holds while `en`=0.
  - Wraps modulo 2^TS_W.
  - A record carries the value of `ts` before that cycle's increment.
- Push condition: `en`=1 and (`foo` or `bar`) at a rising edge.
- `kind` encoding: 2'b01 for foo only, 2'b10 for bar only, 2'b11 for both. 2'b00 never occurs.
- Storage:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits and a separate occupancy counter.
  - Both pointers wrap from DEPTH-1 to 0.
- Pop condition: `evt_valid`=1 and `evt_ready`=1 at a rising edge. The head advances by one.
- Output timing:
  - `evt_valid` = (`level` != 0).
  - `evt_data` is driven from the head entry with no output register.
  - While `evt_valid`=1, `evt_data` stays stable until the record is popped.
- Full, push without pop: the record is dropped. FIFO contents are unchanged and the drop is counted (see Configuration).
- Full, push and pop in the same cycle: both are accepted. `level` stays at DEPTH and nothing is dropped.
- Empty, push and `evt_ready`=1 in the same cycle: the record is written only. There is no fall-through, so the pop takes effect one cycle later.
- Non-full, push and pop in the same cycle: `level` is unchanged.
- `en`=0: no push. Pops continue normally.

## Timing
- Reset values: `evt_valid`=0, `evt_data`=0, `level`=0, `drop_cnt`=0. `ts`=0 and both pointers =0.
- Reset asserted mid-operation clears all queued records immediately. No handshake completes while `rst`=1.
- Push-to-valid latency is 1 cycle. For an edge with a push into an empty FIFO, `evt_valid`=1 is visible right after that edge.
- `level` and `drop_cnt` update on the same edge as the push or pop that changes them.
- Throughput: one push and one pop per cycle.
- The inputs are registered outputs of `foobar` in the same clock domain. No synchronizers are used.

## Configuration
- Macro `FOOBAR_EVT_DROP_CNT_EN`.
- When defined:
  - `drop_cnt` is an 8-bit saturating counter. It increments on each dropped record and holds at 255.
  - It clears only on `rst`.
- When undefined:
  - No counter logic is built.
  - `drop_cnt` is tied to 8'd0.
  - Drops still occur silently under the same full rule.

## Test plan
- Reset then idle: hold `rst`=1 for 13 time units, release, with `foo`=`bar`=0 for 20 cycles. Expect `evt_valid`=0, `level`=0 and `drop_cnt`=0 throughout.
- Single event: at `ts`=5, drive `foo`=1 with `count_foo`=3 and `count_bar`=0, and keep `evt_ready`=1. Expect `evt_valid`=1 on the next cycle with `evt_data`={2'b01, 8'd3, 8'd0, 8'd5}. Expect `level` to return to 0 one cycle later.
- Simultaneous strobes: drive `foo`=`bar`=1 with counts 5 and 3. Expect `kind`=2'b11 and both counts in a single record.
- Fill and overflow: hold `evt_ready`=0 and push 10 events with DEPTH=8. Expect `level`=8 and, with the macro defined, `drop_cnt`=2. Then drain and confirm that exactly the first 8 records come out in order.
- Full with concurrent push and pop: with `level`=8, assert a push and `evt_ready`=1 in the same cycle. Expect `level`=8 and `drop_cnt` unchanged, and the new record to appear as the 8th entry after the pop.
- Wrap and reset: with TS_W=4, run 20 enabled cycles and check that `ts` wraps 15→0 in the records. Assert `rst` mid-burst with `level`=3. Expect `evt_valid`=0 and `level`=0 immediately, before the next clock edge.
